// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
//   state_t : packet assembly state (which byte is expected next)
//   hdr_t   : byte-0 fields kept while bytes 1 and 2 arrive
package ps2_mouse_pkg;

  localparam int unsigned PKT_BYTES = 3;

  // Byte-0 bit positions
  localparam int unsigned BTN_L   = 0;
  localparam int unsigned BTN_R   = 1;
  localparam int unsigned BTN_M   = 2;
  localparam int unsigned ALWAYS1 = 3;
  localparam int unsigned XSIGN   = 4;
  localparam int unsigned YSIGN   = 5;
  localparam int unsigned XOVF    = 6;
  localparam int unsigned YOVF    = 7;

  typedef enum logic [$clog2(PKT_BYTES)-1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2
  } state_t;

  // Byte-0 header without the constant sync bit
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;    // {middle,right,left}
  } hdr_t;

endpackage

// File: rtl/ps2_axis_accum.sv
// One axis of the mouse position: adds a 9-bit signed delta to the current
// position and saturates the result to [0, MAX].
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, position returns to INIT
//   i_en    : apply i_delta this cycle
//   i_delta : 9-bit two's-complement movement
//   o_pos   : registered position
module ps2_axis_accum #(
  parameter int unsigned POS_W  = 12,
  parameter int unsigned MAX    = 639,
  parameter int unsigned INIT   = 320,
  parameter bit          INVERT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_en,
  input  logic [8:0]       i_delta,
  output logic [POS_W-1:0] o_pos
);

  // Two spare bits: one for sign, one for headroom above the position range
  localparam int unsigned SW = POS_W + 2;

  logic [POS_W-1:0]     r_pos;
  logic signed [SW-1:0] w_delta;
  logic signed [SW-1:0] w_step;
  logic signed [SW-1:0] w_sum;
  logic [POS_W-1:0]     w_pos_nxt;

  // Sign-extend, optionally negate (screen y grows downward), then saturate
  always_comb begin
    w_delta   = {{(SW-9){i_delta[8]}}, i_delta};
    w_step    = INVERT ? -w_delta : w_delta;
    w_sum     = $signed({2'b00, r_pos}) + w_step;
    w_pos_nxt = w_sum[POS_W-1:0];
    if (w_sum[SW-1]) begin
      w_pos_nxt = '0;
    end else if (w_sum[SW-2:0] > (SW-1)'(MAX)) begin
      w_pos_nxt = POS_W'(MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pos <= POS_W'(INIT);
    end else if (i_en) begin
      r_pos <= w_pos_nxt;
    end
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream, keeps
// clamped x/y positions and the button state, and flags new packets with a
// sticky valid that ack_i clears.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   rx_valid_i/rx_data_i    : received byte strobe and data
//   rx_err_i                : receive error, qualified by rx_valid_i
//   ack_i                   : clears pkt_valid_o and overrun_o
//   x_pos_o/y_pos_o         : accumulated positions
//   buttons_o               : {middle,right,left} from last packet
//   pkt_valid_o/overrun_o   : sticky new-packet / lost-packet flags
//   sync_err_o              : one-cycle pulse on discarded byte or timeout
module ps2_mouse_packet_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned POS_W          = 12,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MAX          = 479,
  parameter int unsigned X_INIT         = 320,
  parameter int unsigned Y_INIT         = 240,
  parameter bit          Y_INVERT       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_err_i,
  input  logic             ack_i,
  output logic [POS_W-1:0] x_pos_o,
  output logic [POS_W-1:0] y_pos_o,
  output logic [2:0]       buttons_o,
  output logic             pkt_valid_o,
  output logic             overrun_o,
  output logic             sync_err_o
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_to_cnt;
  hdr_t            r_hdr;
  logic [7:0]      r_b1;
  logic [2:0]      r_buttons;
  logic            r_pkt_valid;
  logic            r_overrun;
  logic            r_sync_err;

  logic            w_good;
  logic            w_bad;
  logic            w_timeout;
  logic            w_store_b0;
  logic            w_store_b1;
  logic            w_pkt_done;
  logic            w_sync_err;
  logic [8:0]      w_dx;
  logic [8:0]      w_dy;

  assign w_good    = rx_valid_i & ~rx_err_i;
  assign w_bad     = rx_valid_i & rx_err_i;
  // Timeout only while a packet is partially received and no byte arrives
  assign w_timeout = (r_state != WAIT_B0) && !rx_valid_i &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= WAIT_B0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; receive errors override normal byte handling
  always_comb begin
    w_state_nxt = r_state;
    if (w_bad) begin
      w_state_nxt = WAIT_B0;
    end else if (rx_valid_i) begin
      case (r_state)
        WAIT_B0: if (rx_data_i[ALWAYS1]) w_state_nxt = WAIT_B1;
        WAIT_B1: w_state_nxt = WAIT_B2;
        WAIT_B2: w_state_nxt = WAIT_B0;
        default: w_state_nxt = WAIT_B0;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = WAIT_B0;
    end
  end

  // Per-state action strobes
  always_comb begin
    w_store_b0 = 1'b0;
    w_store_b1 = 1'b0;
    w_pkt_done = 1'b0;
    w_sync_err = w_bad | w_timeout;
    if (w_good) begin
      case (r_state)
        WAIT_B0: begin
          w_store_b0 = rx_data_i[ALWAYS1];
          w_sync_err = ~rx_data_i[ALWAYS1];
        end
        WAIT_B1: w_store_b1 = 1'b1;
        WAIT_B2: w_pkt_done = 1'b1;
        default: w_sync_err = 1'b1;
      endcase
    end
  end

  // Byte storage, flags and idle counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hdr       <= '0;
      r_b1        <= '0;
      r_buttons   <= '0;
      r_pkt_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_sync_err  <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_sync_err <= w_sync_err;
      if (w_store_b0) begin
        r_hdr <= '{y_ovf:  rx_data_i[YOVF],
                   x_ovf:  rx_data_i[XOVF],
                   y_sign: rx_data_i[YSIGN],
                   x_sign: rx_data_i[XSIGN],
                   btn:    {rx_data_i[BTN_M], rx_data_i[BTN_R], rx_data_i[BTN_L]}};
      end
      if (w_store_b1) begin
        r_b1 <= rx_data_i;
      end
      // A packet completing under ack wins: valid set, overrun cleared
      if (w_pkt_done) begin
        r_buttons   <= r_hdr.btn;
        r_pkt_valid <= 1'b1;
        if (ack_i) begin
          r_overrun <= 1'b0;
        end else if (r_pkt_valid) begin
          r_overrun <= 1'b1;
        end
      end else if (ack_i) begin
        r_pkt_valid <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (rx_valid_i || (w_state_nxt == WAIT_B0)) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // Overflowed axes contribute no movement
  assign w_dx = r_hdr.x_ovf ? 9'd0 : {r_hdr.x_sign, r_b1};
  assign w_dy = r_hdr.y_ovf ? 9'd0 : {r_hdr.y_sign, rx_data_i};

  ps2_axis_accum #(
    .POS_W  (POS_W),
    .MAX    (X_MAX),
    .INIT   (X_INIT),
    .INVERT (1'b0)
  ) u_x_accum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_en    (w_pkt_done),
    .i_delta (w_dx),
    .o_pos   (x_pos_o)
  );

  ps2_axis_accum #(
    .POS_W  (POS_W),
    .MAX    (Y_MAX),
    .INIT   (Y_INIT),
    .INVERT (Y_INVERT)
  ) u_y_accum (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_en    (w_pkt_done),
    .i_delta (w_dy),
    .o_pos   (y_pos_o)
  );

  assign buttons_o   = r_buttons;
  assign pkt_valid_o = r_pkt_valid;
  assign overrun_o   = r_overrun;
  assign sync_err_o  = r_sync_err;

endmodule
